// File: rtl/flag_pkg.sv
`default_nettype none
// ==========================================================================
// flag_pkg : op codes, flag bit positions and flag packing helper
// Rev 1.0
// ==========================================================================
package flag_pkg;

  localparam int FLAG_W = 4;

  localparam int FLG_C = 0;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 3;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_CMP  = 3'b001;
  localparam logic [2:0] OP_SET  = 3'b010;
  localparam logic [2:0] OP_CLR  = 3'b011;
  localparam logic [2:0] OP_TGL  = 3'b100;
  localparam logic [2:0] OP_PUSH = 3'b101;
  localparam logic [2:0] OP_POP  = 3'b110;
  localparam logic [2:0] OP_TEST = 3'b111;

  function automatic logic [FLAG_W-1:0] pack_flags(input logic v, input logic z,
                                                   input logic n, input logic c);
    logic [FLAG_W-1:0] f;
    f        = '0;
    f[FLG_V] = v;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_C] = c;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_unit_if.sv
`default_nettype none
// ==========================================================================
// flag_unit_if : op request / flag status bundle for flag_unit
// Rev 1.0
// ==========================================================================
interface flag_unit_if #(parameter int WIDTH = 16);
  import flag_pkg::*;

  logic              op_valid;
  logic [2:0]        op;
  logic [WIDTH-1:0]  ra;
  logic [WIDTH-1:0]  rb;
  logic [FLAG_W-1:0] mask;
  logic              err_clr;
  logic [FLAG_W-1:0] flags;
  logic              done;
  logic              stk_full;
  logic              stk_empty;
  logic              err;

  modport master (
    output op_valid, op, ra, rb, mask, err_clr,
    input  flags, done, stk_full, stk_empty, err
  );

  modport slave (
    input  op_valid, op, ra, rb, mask, err_clr,
    output flags, done, stk_full, stk_empty, err
  );

endinterface
`default_nettype wire

// File: rtl/flag_stack.sv
`default_nettype none
// ==========================================================================
// flag_stack : DEPTH x 4-bit LIFO with full/empty status and fault flag
// Rev 1.0
// ==========================================================================
module flag_stack
  import flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] din,
  output logic [FLAG_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              fault
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]     count;
  logic [FLAG_W-1:0] mem [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign fault   = (push && full) || (pop && empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push_ok) begin
      count <= count + CW'(1);
    end else if (pop_ok) begin
      count <= count - CW'(1);
    end
  end

  // Entry storage carries no reset; only count defines which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (count == CW'(i))) begin
        mem[i] <= din;
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count == CW'(i + 1)) begin
        dout = mem[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ==========================================================================
// flag_unit : condition-flag register with compare/test datapath and save stack
// Rev 1.0
// ==========================================================================
module flag_unit
  import flag_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  flag_unit_if.slave  bus
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic              done_q;
  logic              err_q;

  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  d_res;
  logic [WIDTH-1:0]  and_res;
  logic              cmp_c;
  logic              cmp_v;

  logic              push;
  logic              pop;
  logic              fault;
  logic              full;
  logic              empty;
  logic [FLAG_W-1:0] stk_top;

  // Extra MSB of the widened subtraction is the borrow; carry is its inverse.
  assign diff    = {1'b0, bus.ra} - {1'b0, bus.rb};
  assign d_res   = diff[WIDTH-1:0];
  assign cmp_c   = ~diff[WIDTH];
  assign cmp_v   = (bus.ra[WIDTH-1] != bus.rb[WIDTH-1]) && (d_res[WIDTH-1] != bus.ra[WIDTH-1]);
  assign and_res = bus.ra & bus.rb;

  assign push = bus.op_valid && (bus.op == OP_PUSH);
  assign pop  = bus.op_valid && (bus.op == OP_POP);

  flag_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (flags_q),
    .dout  (stk_top),
    .full  (full),
    .empty (empty),
    .fault (fault)
  );

  always_comb begin
    flags_d = flags_q;
    if (bus.op_valid) begin
      case (bus.op)
        OP_CMP:  flags_d = pack_flags(cmp_v, (d_res == '0), d_res[WIDTH-1], cmp_c);
        OP_SET:  flags_d = flags_q | bus.mask;
        OP_CLR:  flags_d = flags_q & ~bus.mask;
        OP_TGL:  flags_d = flags_q ^ bus.mask;
        OP_POP:  if (!empty) flags_d = stk_top;
        OP_TEST: begin
          flags_d[FLG_Z] = (and_res == '0);
          flags_d[FLG_N] = and_res[WIDTH-1];
        end
        default: flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      done_q  <= bus.op_valid;
      // A fresh fault wins over a simultaneous clear.
      if (fault) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.flags     = flags_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ==========================================================================
// tb_flag_unit : directed self-checking bench for flag_unit (WIDTH=16, DEPTH=4)
// Rev 1.0
// ==========================================================================
module tb_flag_unit;
  import flag_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  flag_unit_if #(.WIDTH(16)) bus ();

  flag_unit #(
    .WIDTH (16),
    .DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single edge, then sample registered outputs 1ns later.
  task automatic step(input logic v, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] m, input logic ec);
    bus.op_valid = v;
    bus.op       = op;
    bus.ra       = a;
    bus.rb       = b;
    bus.mask     = m;
    bus.err_clr  = ec;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.err_clr  = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.ra       = '0;
    bus.rb       = '0;
    bus.mask     = '0;
    bus.err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_flags", bus.flags, 4'b0000);
    check("rst_done", bus.done, 1'b0);
    check("rst_empty", bus.stk_empty, 1'b1);
    check("rst_full", bus.stk_full, 1'b0);
    check("rst_err", bus.err, 1'b0);

    step(1, OP_CMP, 16'h0005, 16'h0005, 4'h0, 0);
    check("cmp_eq_flags", bus.flags, 4'b0101);
    check("cmp_eq_done", bus.done, 1'b1);
    step(0, OP_NOP, 16'h0, 16'h0, 4'h0, 0);
    check("idle_done", bus.done, 1'b0);

    step(1, OP_CMP, 16'h8000, 16'h0001, 4'h0, 0);
    check("cmp_ovf_flags", bus.flags, 4'b1001);
    step(1, OP_CMP, 16'h0001, 16'h0002, 4'h0, 0);
    check("cmp_borrow_flags", bus.flags, 4'b0010);

    step(1, OP_CLR, 16'h0, 16'h0, 4'b1111, 0);
    check("clr_all", bus.flags, 4'b0000);
    step(1, OP_SET, 16'h0, 16'h0, 4'b1010, 0);
    check("set_1010", bus.flags, 4'b1010);
    step(1, OP_TGL, 16'h0, 16'h0, 4'b1111, 0);
    check("tgl_1111", bus.flags, 4'b0101);
    step(1, OP_CLR, 16'h0, 16'h0, 4'b0100, 0);
    check("clr_0100", bus.flags, 4'b0001);

    step(1, OP_TEST, 16'h00F0, 16'h0F00, 4'h0, 0);
    check("test_zero", bus.flags, 4'b0101);
    step(1, OP_TEST, 16'h8001, 16'h8000, 4'h0, 0);
    check("test_neg", bus.flags, 4'b0011);

    step(1, OP_NOP, 16'h1234, 16'h1234, 4'b1111, 0);
    check("nop_flags", bus.flags, 4'b0011);
    check("nop_done", bus.done, 1'b1);

    // Fill the stack with 0011, 1100, 1001, 1010.
    step(1, OP_PUSH, 16'h0, 16'h0, 4'h0, 0);
    check("push1_empty", bus.stk_empty, 1'b0);
    check("push1_flags", bus.flags, 4'b0011);
    step(1, OP_TGL, 16'h0, 16'h0, 4'b1111, 0);
    step(1, OP_PUSH, 16'h0, 16'h0, 4'h0, 0);
    step(1, OP_TGL, 16'h0, 16'h0, 4'b0101, 0);
    step(1, OP_PUSH, 16'h0, 16'h0, 4'h0, 0);
    check("push3_full", bus.stk_full, 1'b0);
    step(1, OP_TGL, 16'h0, 16'h0, 4'b0011, 0);
    check("pre_push4_flags", bus.flags, 4'b1010);
    step(1, OP_PUSH, 16'h0, 16'h0, 4'h0, 0);
    check("push4_full", bus.stk_full, 1'b1);
    check("push4_err", bus.err, 1'b0);
    step(1, OP_TGL, 16'h0, 16'h0, 4'b1111, 0);
    step(1, OP_PUSH, 16'h0, 16'h0, 4'h0, 0);
    check("push5_err", bus.err, 1'b1);
    check("push5_flags", bus.flags, 4'b0101);
    check("push5_full", bus.stk_full, 1'b1);
    step(0, OP_NOP, 16'h0, 16'h0, 4'h0, 1);
    check("errclr_err", bus.err, 1'b0);

    step(1, OP_POP, 16'h0, 16'h0, 4'h0, 0);
    check("pop1_flags", bus.flags, 4'b1010);
    check("pop1_full", bus.stk_full, 1'b0);
    step(1, OP_POP, 16'h0, 16'h0, 4'h0, 0);
    check("pop2_flags", bus.flags, 4'b1001);
    step(1, OP_POP, 16'h0, 16'h0, 4'h0, 0);
    check("pop3_flags", bus.flags, 4'b1100);
    step(1, OP_POP, 16'h0, 16'h0, 4'h0, 0);
    check("pop4_flags", bus.flags, 4'b0011);
    check("pop4_empty", bus.stk_empty, 1'b1);
    check("pop4_err", bus.err, 1'b0);
    step(1, OP_POP, 16'h0, 16'h0, 4'h0, 0);
    check("pop5_flags", bus.flags, 4'b0011);
    check("pop5_err", bus.err, 1'b1);
    check("pop5_empty", bus.stk_empty, 1'b1);

    step(1, OP_POP, 16'h0, 16'h0, 4'h0, 1);
    check("fault_and_clr_err", bus.err, 1'b1);
    step(0, OP_NOP, 16'h0, 16'h0, 4'h0, 1);
    check("clr_alone_err", bus.err, 1'b0);
    check("clr_alone_done", bus.done, 1'b0);

    step(1, OP_PUSH, 16'h0, 16'h0, 4'h0, 0);
    step(1, OP_PUSH, 16'h0, 16'h0, 4'h0, 0);
    check("two_push_empty", bus.stk_empty, 1'b0);
    rst = 1'b1;
    step(1, OP_CMP, 16'h0005, 16'h0005, 4'h0, 0);
    rst = 1'b0;
    check("midrst_flags", bus.flags, 4'b0000);
    check("midrst_empty", bus.stk_empty, 1'b1);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_err", bus.err, 1'b0);
    step(1, OP_POP, 16'h0, 16'h0, 4'h0, 0);
    check("post_rst_pop_err", bus.err, 1'b1);
    check("post_rst_pop_flags", bus.flags, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter WIDTH, default 16, data width of RA/RB operands (>=2).
REQ-002 Parameter DEPTH, default 4, entries in the flag save stack (>=1).
REQ-003 Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-004 Port `clk`: input, 1 bit, rising-edge clock.
REQ-005 Port `rst`: input, 1 bit, synchronous active-high reset.
REQ-006 Port `op_valid`: input, 1 bit, qualifies `op` this cycle.
REQ-007 Port `op`: input, 3 bits, operation code per REQ-013.
REQ-008 Port `ra`, `rb`: input, WIDTH bits each, operands.
REQ-009 Port `mask`: input, 4 bits, flag select for SET/CLR/TGL; bit3=V, bit2=Z, bit1=N, bit0=C.
REQ-010 Port `err_clr`: input, 1 bit, clears sticky `err`.
REQ-011 Ports `flags`: output, 4 bits, registered {V,Z,N,C}; `done`: output, 1 bit, pulses one cycle after any accepted op.
REQ-012 Ports `stk_full`, `stk_empty`, `err`: output, 1 bit each; stack status and sticky stack fault.

Function
REQ-013 Op codes: 000 NOP, 001 CMP, 010 SET, 011 CLR, 100 TGL, 101 PUSH, 110 POP, 111 TEST.
REQ-014 Op accepted only when `op_valid`=1; no backpressure, one op per cycle.
REQ-015 All effects visible on `flags`/status exactly one clock after acceptance; `done`=1 that cycle, 0 otherwise.
REQ-016 CMP: D=ra-rb mod 2^WIDTH; Z=(D==0); N=D[WIDTH-1]; C=1 iff ra>=rb unsigned (no borrow); V=1 iff signed ra-rb overflows.
REQ-017 SET: flags |= mask; CLR: flags &= ~mask; TGL: flags ^= mask.
REQ-018 TEST: Z=((ra&rb)==0), N=(ra&rb)[WIDTH-1]; C, V unchanged.
REQ-019 PUSH: current `flags` stored on stack top, count+1; `flags` unchanged.
REQ-020 POP: `flags` loaded from stack top, count-1.
REQ-021 PUSH when count==DEPTH: no stack change, `err` set; flags unchanged.
REQ-022 POP when count==0: no change to flags or stack, `err` set.
REQ-023 `stk_full`=(count==DEPTH), `stk_empty`=(count==0), registered with stack state.
REQ-024 `err` sticky until `err_clr`; same-cycle new fault and `err_clr` -> `err` stays 1.
REQ-025 NOP with op_valid still produces `done` pulse, no state change.

Reset
REQ-026 On `rst`=1 at a clock edge: flags=0000, count=0, stk_empty=1, stk_full=0, err=0, done=0; stack contents don't-care.
REQ-027 `rst` overrides any op in the same cycle; op discarded, no `done`.
REQ-028 Reset mid-sequence (stack partially filled) discards all saved entries.

Structure
REQ-029 Shared package flag_pkg holds op-code constants, flag bit indices (FLG_C=0, FLG_N=1, FLG_Z=2, FLG_V=3), flag-vector width 4.
REQ-030 Sub-module flag_stack: parameterised DEPTH x 4-bit LIFO with push/pop/full/empty/fault; flag_unit instantiates it once.
REQ-031 Compare/test datapath combinational in flag_unit; single register stage for all outputs.

Verification
REQ-032 WIDTH=16: CMP ra=0x0005 rb=0x0005 -> next cycle flags V0 Z1 N0 C1, done=1.
REQ-033 CMP ra=0x8000 rb=0x0001 -> flags V1 Z0 N0 C1; CMP ra=0x0001 rb=0x0002 -> V0 Z0 N1 C0.
REQ-034 SET mask=1010 from 0000 -> 1010; TGL mask=1111 -> 0101; CLR mask=0100 -> 0001.
REQ-035 DEPTH=4: 4 PUSHes of distinct flags -> stk_full=1, err=0; 5th PUSH -> err=1, stack intact; 4 POPs return values LIFO; 5th POP -> flags held, err=1, stk_empty=1.
REQ-036 err=1, POP on empty with err_clr=1 same cycle -> err remains 1; err_clr alone next cycle -> err=0.
REQ-037 Two PUSHes then rst asserted with CMP op_valid -> next cycle flags=0000, stk_empty=1, done=0, err=0.
